// File: rtl/decode_pkg.sv
// ============================================================================
//  Module      : decode_pkg
//  Description : Decode-stage shared types. Holds the multiply/divide
//                operation enum that the decoder produces for
//                MULT/MULTU/DIV/DIVU, the operand width, and small helpers
//                that the execute-stage multiply/divide unit uses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } muldiv_op_t;

  function automatic logic md_is_signed(input muldiv_op_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Magnitude of a signed operand; unsigned operands pass through.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude 2^31.
  function automatic logic [MULDIV_WIDTH-1:0] md_mag(
    input logic [MULDIV_WIDTH-1:0] x,
    input logic                    is_signed
  );
    return (is_signed && x[MULDIV_WIDTH-1]) ? -x : x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_div_iter.sv
// ============================================================================
//  Module      : muldiv_div_iter
//  Description : Restoring radix-2 divider datapath. Loads operand
//                magnitudes, performs one quotient bit per step on a
//                {rem[32:0], quo[31:0]} register, and presents the signed
//                result of the *next* step combinationally so the caller can
//                capture the final answer on the same edge as the last step.
//  Ports       : clk, resetn      - clock, synchronous active-low reset
//                load             - capture dividend/divisor and sign flags
//                step             - advance one restoring iteration
//                is_signed        - DIV (1) or DIVU (0)
//                dividend/divisor - raw rs / rt operands
//                quo_res/rem_res  - sign-fixed quotient / remainder after
//                                   the step currently being taken
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_div_iter
  import decode_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_signed,
  input  logic [MULDIV_WIDTH-1:0] dividend,
  input  logic [MULDIV_WIDTH-1:0] divisor,
  output logic [MULDIV_WIDTH-1:0] quo_res,
  output logic [MULDIV_WIDTH-1:0] rem_res
);

  logic [MULDIV_WIDTH:0]   rem;
  logic [MULDIV_WIDTH-1:0] quo;
  logic [MULDIV_WIDTH-1:0] dvs;
  logic                    neg_q;
  logic                    neg_r;
  logic                    div0;

  logic [MULDIV_WIDTH+1:0] shifted;
  logic [MULDIV_WIDTH+1:0] diff;
  logic                    take;
  logic [MULDIV_WIDTH:0]   rem_nxt;
  logic [MULDIV_WIDTH-1:0] quo_nxt;

  always_comb begin
    // The partial remainder is always below the divisor, so the upper
    // bits of the shifted value are zero; the borrow of the subtraction
    // decides the quotient bit.
    shifted = {rem, quo[MULDIV_WIDTH-1]};
    diff    = shifted - {2'b00, dvs};
    take    = ~diff[MULDIV_WIDTH+1];
    rem_nxt = take ? diff[MULDIV_WIDTH:0] : shifted[MULDIV_WIDTH:0];
    quo_nxt = {quo[MULDIV_WIDTH-2:0], take};

    // Divide by zero: every step "succeeds", leaving all-ones quotient and
    // the dividend magnitude as remainder. Restoring the dividend sign on
    // the remainder yields the raw dividend; the quotient is forced to
    // all-ones so the quotient sign fixup cannot disturb it.
    quo_res = div0  ? '1 : (neg_q ? -quo_nxt : quo_nxt);
    rem_res = neg_r ? -rem_nxt[MULDIV_WIDTH-1:0] : rem_nxt[MULDIV_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (load) begin
      rem   <= '0;
      quo   <= md_mag(dividend, is_signed);
      dvs   <= md_mag(divisor, is_signed);
      neg_q <= is_signed & (dividend[MULDIV_WIDTH-1] ^ divisor[MULDIV_WIDTH-1]);
      neg_r <= is_signed & dividend[MULDIV_WIDTH-1];
      div0  <= (divisor == '0);
    end else if (step) begin
      rem   <= rem_nxt;
      quo   <= quo_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/execute_muldiv.sv
// ============================================================================
//  Module      : execute_muldiv
//  Description : Execute-stage iterative multiply/divide unit producing the
//                64-bit HI/LO result. Holds the control FSM, the iteration
//                counter, the multiplier and the HI/LO output registers; the
//                restoring divider lives in muldiv_div_iter.
//  Ports       : clk, resetn  - clock, synchronous active-low reset
//                flush        - abort the current operation (flushE)
//                in_valid     - E holds MULT/MULTU/DIV/DIVU
//                op, a, b     - operation and rs/rt operands
//                accept       - pipeline advances out of E (~stallE)
//                busy, done   - iterating / result valid
//                stall_req    - in_valid & ~done, to the hazard unit
//                hi, lo       - HI/LO results
//  Config      : MULDIV_FAST_MULT_EN - single-cycle combinational multiply
//                (done one cycle after start); otherwise a 32-step
//                shift-add multiply. Division is always iterative.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module execute_muldiv
  import decode_pkg::*;
#(
  parameter int DIV_ITERS = 32,
  parameter int MUL_ITERS = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    in_valid,
  input  muldiv_op_t              op,
  input  logic [MULDIV_WIDTH-1:0] a,
  input  logic [MULDIV_WIDTH-1:0] b,
  input  logic                    accept,
  output logic                    busy,
  output logic                    done,
  output logic                    stall_req,
  output logic [MULDIV_WIDTH-1:0] hi,
  output logic [MULDIV_WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MAX_ITERS = (DIV_ITERS > MUL_ITERS) ? DIV_ITERS : MUL_ITERS;
  localparam int CNT_W     = $clog2(MAX_ITERS + 1);

  muldiv_state_t state, state_nxt;
  logic [CNT_W-1:0] counter;

  logic op_signed;
  logic op_div;
  logic start;
  logic div_last;
  logic mul_last;

  logic [MULDIV_WIDTH-1:0]   quo_res;
  logic [MULDIV_WIDTH-1:0]   rem_res;
  logic [2*MULDIV_WIDTH-1:0] mul_res;

  assign op_signed = md_is_signed(op);
  assign op_div    = md_is_div(op);
  assign start     = (state == IDLE) && in_valid && !flush;
  assign div_last  = (counter == CNT_W'(DIV_ITERS - 1));
  assign mul_last  = (counter == CNT_W'(MUL_ITERS - 1));
  assign stall_req = in_valid & ~done;

`ifdef MULDIV_FAST_MULT_EN
  logic signed [2*MULDIV_WIDTH+1:0] fast_prod;

  // 33x33 signed product: the extra top bit is the operand sign for
  // MULT and zero for MULTU, so one multiplier serves both.
  always_comb begin
    fast_prod = $signed({op_signed & a[MULDIV_WIDTH-1], a}) *
                $signed({op_signed & b[MULDIV_WIDTH-1], b});
    mul_res   = fast_prod[2*MULDIV_WIDTH-1:0];
  end
`else
  logic [MULDIV_WIDTH-1:0]   mcand;
  logic [2*MULDIV_WIDTH-1:0] mul_acc;
  logic                      mul_neg;
  logic [MULDIV_WIDTH:0]     mul_sum;
  logic [2*MULDIV_WIDTH-1:0] mul_step;

  // Shift-add on magnitudes: the multiplier sits in the low half and is
  // consumed LSB first while partial sums enter the high half.
  always_comb begin
    mul_sum  = {1'b0, mul_acc[2*MULDIV_WIDTH-1:MULDIV_WIDTH]} +
               {1'b0, (mul_acc[0] ? mcand : '0)};
    mul_step = {mul_sum, mul_acc[MULDIV_WIDTH-1:1]};
    mul_res  = mul_neg ? -mul_step : mul_step;
  end
`endif

  muldiv_div_iter u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load      (start && op_div),
    .step      ((state == DIV) && !flush),
    .is_signed (op_signed),
    .dividend  (a),
    .divisor   (b),
    .quo_res   (quo_res),
    .rem_res   (rem_res)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op_div) begin
            state_nxt = DIV;
          end else begin
`ifdef MULDIV_FAST_MULT_EN
            state_nxt = DONE;
`else
            state_nxt = MUL;
`endif
          end
        end
      end
      MUL: begin
        busy = 1'b1;
        if (mul_last) state_nxt = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (div_last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      counter <= '0;
      hi      <= '0;
      lo      <= '0;
`ifndef MULDIV_FAST_MULT_EN
      mcand   <= '0;
      mul_acc <= '0;
      mul_neg <= 1'b0;
`endif
    end else begin
      if (start) begin
        counter <= '0;
      end else if (busy && !flush) begin
        counter <= counter + CNT_W'(1);
      end

`ifndef MULDIV_FAST_MULT_EN
      if (start && !op_div) begin
        mcand   <= md_mag(a, op_signed);
        mul_acc <= {{MULDIV_WIDTH{1'b0}}, md_mag(b, op_signed)};
        mul_neg <= op_signed & (a[MULDIV_WIDTH-1] ^ b[MULDIV_WIDTH-1]);
      end else if ((state == MUL) && !flush) begin
        mul_acc <= mul_step;
      end
`endif

      // HI/LO only change when a result completes; a flush leaves them.
      if (!flush) begin
`ifdef MULDIV_FAST_MULT_EN
        if (start && !op_div) begin
          hi <= mul_res[2*MULDIV_WIDTH-1:MULDIV_WIDTH];
          lo <= mul_res[MULDIV_WIDTH-1:0];
        end
`else
        if ((state == MUL) && mul_last) begin
          hi <= mul_res[2*MULDIV_WIDTH-1:MULDIV_WIDTH];
          lo <= mul_res[MULDIV_WIDTH-1:0];
        end
`endif
        if ((state == DIV) && div_last) begin
          hi <= rem_res;
          lo <= quo_res;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_execute_muldiv.sv
// ============================================================================
//  Module      : tb_execute_muldiv
//  Description : Self-checking bench for execute_muldiv. A behavioural
//                reference computes HI/LO with plain integer arithmetic and
//                tracks completion with a cycle countdown; a compare process
//                checks every output each cycle. Directed cases pin the
//                reference with literal results, then randomized operations
//                run against it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_execute_muldiv;
  import decode_pkg::*;

  logic        clk      = 1'b0;
  logic        resetn   = 1'b0;
  logic        flush    = 1'b0;
  logic        in_valid = 1'b0;
  logic        accept   = 1'b0;
  muldiv_op_t  op       = MD_MULT;
  logic [31:0] a        = '0;
  logic [31:0] b        = '0;
  logic        busy, done, stall_req;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  execute_muldiv dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .accept    (accept),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MD_MULT:  res = sx * sy;
      MD_MULTU: res = {32'd0, x} * {32'd0, y};
      MD_DIV: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic int ref_latency(input muldiv_op_t o);
`ifdef MULDIV_FAST_MULT_EN
    if (o == MD_MULT || o == MD_MULTU) return 1;
`endif
    return 33;
  endfunction

  logic        m_active, m_done;
  int          m_left;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;

  always @(posedge clk) begin
    if (!resetn) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_left   <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
    end else if (flush) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
    end else if (m_done) begin
      if (accept) m_done <= 1'b0;
    end else if (m_active) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
        m_hi     <= p_hi;
        m_lo     <= p_lo;
      end
    end else if (in_valid) begin
      {p_hi, p_lo} <= ref_result(op, a, b);
      if (ref_latency(op) == 1) begin
        m_done       <= 1'b1;
        {m_hi, m_lo} <= ref_result(op, a, b);
      end else begin
        m_active <= 1'b1;
        m_left   <= ref_latency(op) - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("busy",      64'(busy),      64'(m_active));
      check("done",      64'(done),      64'(m_done));
      check("stall_req", 64'(stall_req), 64'(in_valid & ~m_done));
      check("hi",        64'(hi),        64'(m_hi));
      check("lo",        64'(lo),        64'(m_lo));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                       input int hold, input bit lit, input logic [31:0] ehi, input logic [31:0] elo);
    int lat = 0;
    int st  = 0;
    logic [31:0] shi, slo;
    op = o; a = x; b = y; in_valid = 1'b1; accept = 1'b0;
    while (1) begin
      @(negedge clk);
      if (done) break;
      if (stall_req) st++;
      lat++;
      if (lat > 200) break;
    end
    check("latency", 64'(lat), 64'(ref_latency(o)));
    check("stall_cycles", 64'(st), 64'(ref_latency(o)));
    if (lit) begin
      check("lit_hi", 64'(hi), 64'(ehi));
      check("lit_lo", 64'(lo), 64'(elo));
    end
    shi = hi;
    slo = lo;
    if (hold > 0) begin
      repeat (hold) cyc();
      check("hold_done", 64'(done), 64'd1);
      check("hold_busy", 64'(busy), 64'd0);
      check("hold_hi",   64'(hi),   64'(shi));
      check("hold_lo",   64'(lo),   64'(slo));
    end
    accept = 1'b1;
    cyc();
    accept = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    muldiv_op_t ro;
    logic [31:0] ra, rb;

    resetn = 1'b0;
    cyc();
    cyc();
    checking = 1'b1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi",   64'(hi),   64'd0);
    check("rst_lo",   64'(lo),   64'd0);
    resetn = 1'b1;

    do_op(MD_DIVU,  32'd100,        32'd7,          0, 1'b1, 32'd2,          32'd14);
    do_op(MD_DIV,   32'hFFFF_FFF9,  32'd2,          0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFD);
    do_op(MD_DIV,   32'h8000_0000,  32'hFFFF_FFFF,  4, 1'b1, 32'd0,          32'h8000_0000);
    do_op(MD_MULT,  32'hFFFF_FFFF,  32'd2,          0, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFE);
    do_op(MD_MULTU, 32'hFFFF_FFFF,  32'd2,          2, 1'b1, 32'd1,          32'hFFFF_FFFE);
    do_op(MD_DIVU,  32'h0000_1234,  32'd0,          0, 1'b1, 32'h0000_1234,  32'hFFFF_FFFF);
    in_valid = 1'b0;
    cyc();

    // Flush in the middle of a divide, then an immediate multiply.
    op = MD_DIV; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    repeat (10) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    do_op(MD_MULTU, 32'd3, 32'd5, 0, 1'b1, 32'd0, 32'd15);
    in_valid = 1'b0;
    cyc();

    // Reset in the middle of a divide.
    op = MD_DIV; a = 32'hDEAD_BEEF; b = 32'd17; in_valid = 1'b1;
    repeat (5) cyc();
    resetn = 1'b0;
    cyc();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_hi",   64'(hi),   64'd0);
    check("midrst_lo",   64'(lo),   64'd0);
    resetn = 1'b1;
    in_valid = 1'b0;
    cyc();

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(ro, ra, rb, $urandom_range(0, 3), 1'b0, 32'd0, 32'd0);
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
      end
    end
    in_valid = 1'b0;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
